prog_loader: RTL and testbench

- Byte-stream program loader: fills the pipe_MIPS32 instruction/data memory from an external byte source, then releases the processor.
- Replaces hierarchical memory preloading on silicon/FPGA builds.
- Sits between a host byte link (UART/JTAG bridge) and the memory write port.
- Holds the CPU until the image is fully written.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream and memory write-port bundle for the program loader.
// The loader takes the slave side; the byte source and memory sit on the master side.
interface prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a 16-bit word count plus big-endian words,
// writes them to instruction/data memory and releases the CPU when complete.
module prog_loader #(
    parameter int ADDR_W        = 10,
    parameter int WORD_W        = 32,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         cpu_start,
    output logic         load_done,
    output logic         load_err,
    output logic [15:0]  word_cnt
);

    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         widx_q, widx_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [WORD_W-9:0]   asm_q, asm_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                cpu_start_q, cpu_start_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic                ready;
    logic                hs;
    logic                in_range;
    logic                finish;

    assign in_range = (32'(widx_q) < (32'd1 << ADDR_W));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;
        cpu_hold_d  = cpu_hold_q;
        cpu_start_d = 1'b0;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        finish      = 1'b0;
        ready       = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
        hs          = ready && bus.in_valid;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = HDR_HI;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    word_cnt_d  = 16'd0;
                    cpu_hold_d  = 1'b1;
                    cnt_d       = 16'd0;
                    widx_d      = 16'd0;
                    bidx_d      = 2'd0;
                end
            end
            HDR_HI, HDR_LO, DATA: begin
                if (abort) begin
                    // Partial word is dropped; words already written stay in memory.
                    state_d    = IDLE;
                    load_err_d = 1'b1;
                    bidx_d     = 2'd0;
                end else if (hs) begin
                    if (state_q == HDR_HI) begin
                        cnt_d[15:8] = bus.in_data;
                        state_d     = HDR_LO;
                    end else if (state_q == HDR_LO) begin
                        cnt_d[7:0] = bus.in_data;
                        state_d    = (cnt_d == 16'd0) ? DONE : DATA;
                    end else if (bidx_q == 2'd3) begin
                        bidx_d = 2'd0;
                        widx_d = widx_q + 16'd1;
                        // Words past the end of memory are swallowed so the stream stays in sync.
                        if (in_range) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = widx_q[ADDR_W-1:0];
                            mem_wdata_d = {asm_q, bus.in_data};
                            word_cnt_d  = word_cnt_q + 16'd1;
                        end else begin
                            load_err_d = 1'b1;
                        end
                        if (widx_d == cnt_q) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        asm_d  = {asm_q[WORD_W-17:0], bus.in_data};
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
                finish  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                // An empty image skips FLUSH, so completion is issued one state later.
                finish  = (cnt_q == 16'd0);
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            cpu_start_d = !load_err_q;
            cpu_hold_d  = load_err_q;
            load_done_d = !load_err_q;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
            cpu_hold_q  <= HOLD_AT_RESET;
            cpu_start_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
            cpu_hold_q  <= cpu_hold_d;
            cpu_start_q <= cpu_start_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign cpu_start     = cpu_start_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
    assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a full-size instance and a 4-word (ADDR_W=2) instance share one byte stream.
module tb_prog_loader;

    logic        clk1;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        hold_a, cstart_a, done_a, err_a;
    logic [15:0] wcnt_a;
    logic        hold_b, cstart_b, done_b, err_b;
    logic [15:0] wcnt_b;

    prog_loader_if #(.ADDR_W(10), .WORD_W(32)) if_a ();
    prog_loader_if #(.ADDR_W(2),  .WORD_W(32)) if_b ();

    assign if_a.in_data  = in_data;
    assign if_a.in_valid = in_valid;
    assign if_b.in_data  = in_data;
    assign if_b.in_valid = in_valid;

    prog_loader #(.ADDR_W(10), .WORD_W(32), .HOLD_AT_RESET(1'b1)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort), .bus(if_a.slave),
        .cpu_hold(hold_a), .cpu_start(cstart_a), .load_done(done_a), .load_err(err_a),
        .word_cnt(wcnt_a)
    );

    prog_loader #(.ADDR_W(2), .WORD_W(32), .HOLD_AT_RESET(1'b1)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort), .bus(if_b.slave),
        .cpu_hold(hold_b), .cpu_start(cstart_b), .load_done(done_b), .load_err(err_b),
        .word_cnt(wcnt_b)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    logic [9:0]  wa_addr[$];
    logic [31:0] wa_data[$];
    logic [1:0]  wb_addr[$];
    logic [31:0] wb_data[$];
    int starts_a = 0;
    int starts_b = 0;
    int start_cyc_a = -1;
    int last_we_cyc = -1;

    always @(negedge clk1) begin
        if (if_a.mem_we) begin
            wa_addr.push_back(if_a.mem_addr);
            wa_data.push_back(if_a.mem_wdata);
            last_we_cyc = cyc;
        end
        if (if_b.mem_we) begin
            wb_addr.push_back(if_b.mem_addr);
            wb_data.push_back(if_b.mem_wdata);
        end
        if (cstart_a) begin
            starts_a++;
            start_cyc_a = cyc;
        end
        if (cstart_b) starts_b++;
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [9:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl[9];

    int checks = 0;
    int errors = 0;
    int last_hs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; returns at the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk1);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!(if_a.in_ready && if_b.in_ready) && t < 50) begin
            @(negedge clk1);
            t++;
        end
        checks++;
        if (!(if_a.in_ready && if_b.in_ready)) begin
            errors++;
            $display("FAIL byte_accept: in_ready a=%0b b=%0b required 1 for byte %h",
                     if_a.in_ready, if_b.in_ready, b);
        end
        @(posedge clk1);
        #1 last_hs = cyc;
        @(negedge clk1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input int i, input bit rnd);
        send_byte(tbl[i].b0, rnd ? int'($urandom_range(0, 3)) : 0);
        send_byte(tbl[i].b1, rnd ? int'($urandom_range(0, 3)) : 0);
        send_byte(tbl[i].b2, rnd ? int'($urandom_range(0, 3)) : 0);
        send_byte(tbl[i].b3, rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic load_image(input int n, input bit rnd);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'(n), 0);
        for (int i = 0; i < n; i++) send_word(i, rnd);
    endtask

    task automatic check_writes_a(input string name, input int base, input int n);
        chk({name, "_nwr"}, 32'(wa_addr.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < wa_addr.size()) begin
                chk({name, "_addr"}, 32'(wa_addr[base + i]), 32'(tbl[i].exp_addr));
                chk({name, "_data"}, wa_data[base + i], tbl[i].exp_data);
            end
        end
    endtask

    task automatic check_success_a(input string name, input int n, input int s0);
        chk({name, "_starts"},    32'(starts_a - s0), 32'd1);
        chk({name, "_start_lat"}, 32'(start_cyc_a),   32'(last_hs + 1));
        chk({name, "_done"},      32'(done_a),        32'd1);
        chk({name, "_err"},       32'(err_a),         32'd0);
        chk({name, "_hold"},      32'(hold_a),        32'd0);
        chk({name, "_wcnt"},      32'(wcnt_a),        32'(n));
        chk({name, "_ready"},     32'(if_a.in_ready), 32'd0);
    endtask

    int wa0, wb0, s0, sb0;

    initial begin
        tbl[0] = '{8'h28, 8'h01, 8'h00, 8'h0a, 10'd0, 32'h2801000a};
        tbl[1] = '{8'h28, 8'h02, 8'h00, 8'h14, 10'd1, 32'h28020014};
        tbl[2] = '{8'h28, 8'h03, 8'h00, 8'h19, 10'd2, 32'h28030019};
        tbl[3] = '{8'h0c, 8'he7, 8'h78, 8'h00, 10'd3, 32'h0ce77800};
        tbl[4] = '{8'h0c, 8'he7, 8'h78, 8'h00, 10'd4, 32'h0ce77800};
        tbl[5] = '{8'h00, 8'h22, 8'h20, 8'h00, 10'd5, 32'h00222000};
        tbl[6] = '{8'h0c, 8'he7, 8'h78, 8'h00, 10'd6, 32'h0ce77800};
        tbl[7] = '{8'h00, 8'h83, 8'h28, 8'h00, 10'd7, 32'h00832800};
        tbl[8] = '{8'hfc, 8'h00, 8'h00, 8'h00, 10'd8, 32'hfc000000};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);

        // Reset state after idling
        chk("rst_hold_a",  32'(hold_a),         32'd1);
        chk("rst_hold_b",  32'(hold_b),         32'd1);
        chk("rst_ready",   32'(if_a.in_ready),  32'd0);
        chk("rst_nwr",     32'(wa_addr.size()), 32'd0);
        chk("rst_cstart",  32'(starts_a),       32'd0);
        chk("rst_done",    32'(done_a),         32'd0);
        chk("rst_err",     32'(err_a),          32'd0);
        chk("rst_wcnt",    32'(wcnt_a),         32'd0);
        chk("rst_addr",    32'(if_a.mem_addr),  32'd0);
        chk("rst_wdata",   if_a.mem_wdata,      32'd0);

        // Nine-word image, back-to-back bytes
        wa0 = wa_addr.size(); s0 = starts_a;
        load_image(9, 1'b0);
        repeat (4) @(negedge clk1);
        check_writes_a("img", wa0, 9);
        chk("img_we_lat", 32'(last_we_cyc), 32'(last_hs));
        check_success_a("img", 9, s0);
        chk("img_hold_addr",  32'(if_a.mem_addr), 32'd8);
        chk("img_hold_wdata", if_a.mem_wdata,     32'hfc000000);

        // Same image with random valid gaps
        wa0 = wa_addr.size(); s0 = starts_a;
        load_image(9, 1'b1);
        repeat (4) @(negedge clk1);
        check_writes_a("gap", wa0, 9);
        check_success_a("gap", 9, s0);

        // Empty image
        wa0 = wa_addr.size(); s0 = starts_a;
        load_image(0, 1'b0);
        repeat (4) @(negedge clk1);
        chk("empty_nwr", 32'(wa_addr.size() - wa0), 32'd0);
        check_success_a("empty", 0, s0);

        // Six words into a four-word memory (instance b)
        wa0 = wa_addr.size(); wb0 = wb_addr.size(); s0 = starts_a; sb0 = starts_b;
        load_image(6, 1'b0);
        repeat (4) @(negedge clk1);
        chk("ovf_nwr", 32'(wb_addr.size() - wb0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wb0 + i < wb_addr.size()) begin
                chk("ovf_addr", 32'(wb_addr[wb0 + i]), 32'(i));
                chk("ovf_data", wb_data[wb0 + i],      tbl[i].exp_data);
            end
        end
        chk("ovf_err",    32'(err_b),           32'd1);
        chk("ovf_done",   32'(done_b),          32'd0);
        chk("ovf_wcnt",   32'(wcnt_b),          32'd4);
        chk("ovf_starts", 32'(starts_b - sb0),  32'd0);
        chk("ovf_hold",   32'(hold_b),          32'd1);
        chk("ovf_ready",  32'(if_b.in_ready),   32'd0);
        check_writes_a("ovf_big", wa0, 6);
        check_success_a("ovf_big", 6, s0);

        // Abort after two words plus two bytes, with an ignored start mid-session
        wa0 = wa_addr.size(); s0 = starts_a;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        send_word(0, 1'b0);
        pulse_start();
        send_word(1, 1'b0);
        send_byte(tbl[2].b0, 0);
        send_byte(tbl[2].b1, 0);
        abort = 1'b1;
        @(negedge clk1);
        abort = 1'b0;
        repeat (4) @(negedge clk1);
        check_writes_a("abort", wa0, 2);
        chk("abort_err",    32'(err_a),          32'd1);
        chk("abort_done",   32'(done_a),         32'd0);
        chk("abort_hold",   32'(hold_a),         32'd1);
        chk("abort_ready",  32'(if_a.in_ready),  32'd0);
        chk("abort_wcnt",   32'(wcnt_a),         32'd2);
        chk("abort_starts", 32'(starts_a - s0),  32'd0);

        // Reload after abort
        wa0 = wa_addr.size(); s0 = starts_a;
        load_image(9, 1'b0);
        repeat (4) @(negedge clk1);
        check_writes_a("reload", wa0, 9);
        check_success_a("reload", 9, s0);

        // Asynchronous reset in the middle of a session, between clock edges
        wa0 = wa_addr.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        send_word(0, 1'b0);
        send_byte(8'h12, 0);
        wa0 = wa_addr.size();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hold",  32'(hold_a),         32'd1);
        chk("arst_ready", 32'(if_a.in_ready),  32'd0);
        chk("arst_we",    32'(if_a.mem_we),    32'd0);
        chk("arst_wcnt",  32'(wcnt_a),         32'd0);
        chk("arst_addr",  32'(if_a.mem_addr),  32'd0);
        chk("arst_wdata", if_a.mem_wdata,      32'd0);
        chk("arst_done",  32'(done_a),         32'd0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        in_data = 8'h55; in_valid = 1'b1;
        repeat (8) @(negedge clk1);
        in_valid = 1'b0;
        chk("arst_nwr",   32'(wa_addr.size() - wa0), 32'd0);
        chk("arst_idle",  32'(if_a.in_ready),        32'd0);
        chk("arst_wcnt2", 32'(wcnt_a),               32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
